attn_ram_reader: RTL and testbench

Downstream consumer of the double-buffered Q·K^T attention RAM. It waits for a full 64×64 score matrix to be available (RAM not empty) and sweeps read addresses 0..4095. It absorbs the RAM's 1-cycle read latency behind a 2-entry output buffer and streams scores with row/column tags to the attention-times-V stage under valid/ready backpressure. After the last beat it pulses the RAM's done input to release the buffer for the next head.

---
 rtl/attn_ram_reader.sv | 198 +++++++++++++++++++
 tb/tb_attn_ram_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_ram_reader.sv
// attn_ram_reader: sweeps a 64x64 score matrix out of the attention RAM and streams tagged beats.
// Latency: first beat valid 2 cycles after entering STREAM; 1 beat/cycle sustained with ready high.
// Backpressure: 2-entry buffer absorbs the 1-cycle RAM latency; reads stall when buffer + in-flight would exceed 2.
module attn_ram_reader #(
  parameter int DATA_W = 20,
  parameter int DIM    = 64,
  parameter int ADDR_W = 12,
  parameter int IDX_W  = $clog2(DIM)
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_ram_empty,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic              o_ram_done,
  output logic              m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_row,
  output logic [IDX_W-1:0]  m_col,
  output logic              m_last_col,
  output logic              m_last,
  output logic              o_busy
);

  // Final address of the sweep and the final column index.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DIM * DIM - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIM - 1);
  // GAP lasts two cycles: counter values 0 and 1.
  localparam logic [1:0]        GAP_LAST  = 2'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STREAM  = 3'd1,
    DRAIN   = 3'd2,
    RELEASE = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Read issue side.
  logic [ADDR_W-1:0] r_issue_cnt;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;

  // Two-entry output buffer holding returned data with its address tag.
  logic [DATA_W-1:0] r_buf_dat  [2];
  logic [ADDR_W-1:0] r_buf_addr [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic [1:0]        r_gap_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic [1:0]        w_count_nxt;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_done;
  logic              w_busy;

  // Buffer bookkeeping and the issue rule: never let buffer + in-flight exceed two entries.
  always_comb begin
    w_push      = r_inflight;
    w_pop       = (r_count != 2'd0) && i_m_ready;
    w_occ       = {1'b0, r_count} + {2'b00, r_inflight};
    w_issue     = (r_state == STREAM) && (w_occ < (3'd2 + {2'b00, w_pop}));
    w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // State register.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore outputs; DRAIN looks at next-cycle occupancy so done follows the last handshake directly.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (!i_ram_empty) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_issue && (r_issue_cnt == LAST_ADDR)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_inflight && (w_count_nxt == 2'd0)) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        w_done      = 1'b1;
        w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Issue counter doubles as the RAM address; it only moves when a read is issued.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_issue_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_issue_cnt <= '0;
    end else if (w_issue) begin
      r_issue_cnt <= r_issue_cnt + 1'b1;
    end
  end

  // Track the single outstanding read and remember which address it was for.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_issue_cnt;
      end
    end
  end

  // Capture returned data into the buffer one cycle after issue.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_buf_dat[0]  <= '0;
      r_buf_dat[1]  <= '0;
      r_buf_addr[0] <= '0;
      r_buf_addr[1] <= '0;
    end else if (w_push) begin
      r_buf_dat[r_wr_ptr]  <= i_ram_data;
      r_buf_addr[r_wr_ptr] <= r_inflight_addr;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
    end
  end

  // GAP dwell counter; zero outside GAP so each visit starts fresh.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_gap_cnt <= 2'd0;
    end else if (r_state == GAP) begin
      r_gap_cnt <= r_gap_cnt + 2'd1;
    end else begin
      r_gap_cnt <= 2'd0;
    end
  end

  // Beat fields come straight from the buffer head; row/col are slices since DIM is a power of two.
  assign w_head_addr   = r_buf_addr[r_rd_ptr];
  assign m_valid       = (r_count != 2'd0);
  assign m_data        = r_buf_dat[r_rd_ptr];
  assign m_row         = w_head_addr[2*IDX_W-1:IDX_W];
  assign m_col         = w_head_addr[IDX_W-1:0];
  assign m_last_col    = (w_head_addr[IDX_W-1:0] == LAST_IDX);
  assign m_last        = (w_head_addr == LAST_ADDR);
  assign o_ram_rd_addr = r_issue_cnt;
  assign o_ram_done    = w_done;
  assign o_busy        = w_busy;

endmodule

// File: tb/tb_attn_ram_reader.sv
// tb_attn_ram_reader: bench for attn_ram_reader with a banked RAM model and a beat scoreboard.
// Latency: expects first beat 3 edges after i_ram_empty drops, 1 beat/cycle with ready high.
// Backpressure: random ready exercises stalls; held beats must stay stable.
`timescale 1ns/1ps
module tb_attn_ram_reader;
  localparam int DATA_W = 20;
  localparam int DIM    = 64;
  localparam int ADDR_W = 12;
  localparam int IDX_W  = 6;
  localparam int NBEATS = DIM * DIM;

  typedef logic [DATA_W+2*IDX_W+1:0] exp_t;

  logic              s_clk = 1'b0;
  logic              s_rst = 1'b1;
  logic              i_ram_empty = 1'b1;
  logic [ADDR_W-1:0] o_ram_rd_addr;
  logic [DATA_W-1:0] i_ram_data;
  logic              o_ram_done;
  logic              m_valid;
  logic              i_m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_row;
  logic [IDX_W-1:0]  m_col;
  logic              m_last_col;
  logic              m_last;
  logic              o_busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  int   cyc = 0;
  int   beat_cnt = 0;
  int   lastcol_cnt = 0;
  int   last_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   vld_rise_cyc = 0;
  int   first_hs_cyc = 0;
  int   last_hs_cyc = 0;
  bit   rand_ready = 1'b0;

  // Banked RAM model: 1-cycle read latency, bank swaps on each done pulse.
  logic              ram_bank = 1'b0;
  logic [DATA_W-1:0] ram_q = '0;

  attn_ram_reader #(
    .DATA_W(DATA_W), .DIM(DIM), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_ram_empty(i_ram_empty),
    .o_ram_rd_addr(o_ram_rd_addr), .i_ram_data(i_ram_data), .o_ram_done(o_ram_done),
    .m_valid(m_valid), .i_m_ready(i_m_ready), .m_data(m_data), .m_row(m_row),
    .m_col(m_col), .m_last_col(m_last_col), .m_last(m_last), .o_busy(o_busy)
  );

  initial forever #5 s_clk = ~s_clk;

  initial forever begin
    @(posedge s_clk);
    cyc++;
  end

  always @(posedge s_clk) begin
    ram_q <= ram_bank ? (DATA_W'(o_ram_rd_addr) + 20'h08000) : DATA_W'(o_ram_rd_addr);
    if (o_ram_done) ram_bank <= ~ram_bank;
  end
  assign i_ram_data = ram_q;

  initial forever begin
    @(posedge s_clk);
    #1;
    if (rand_ready) i_m_ready = ($urandom_range(0, 1) == 1);
  end

  function automatic logic [DATA_W-1:0] bank_off(input logic b);
    return b ? 20'h08000 : 20'h00000;
  endfunction

  task automatic push_matrix(input logic [DATA_W-1:0] off);
    for (int a = 0; a < NBEATS; a++) begin
      logic [IDX_W-1:0]  r;
      logic [IDX_W-1:0]  c;
      logic [DATA_W-1:0] d;
      logic              lc;
      logic              lst;
      r   = IDX_W'(a / DIM);
      c   = IDX_W'(a % DIM);
      d   = DATA_W'(a) + off;
      lc  = ((a % DIM) == DIM - 1);
      lst = (a == NBEATS - 1);
      sb_q.push_back({d, r, c, lc, lst});
    end
  endtask

  // Scoreboard monitor: compares every handshake, held-beat stability and done timing.
  initial begin : monitor
    exp_t got;
    exp_t exp;
    exp_t held;
    logic prev_stall;
    logic prev_hs_last;
    logic prev_vld;
    prev_stall = 1'b0; prev_hs_last = 1'b0; prev_vld = 1'b0; held = '0;
    forever begin
      @(negedge s_clk);
      if (s_rst) begin
        prev_stall = 1'b0; prev_hs_last = 1'b0; prev_vld = 1'b0;
      end else begin
        got = {m_data, m_row, m_col, m_last_col, m_last};
        if (prev_stall) begin
          checks++;
          if (m_valid !== 1'b1 || got !== held) begin
            errors++;
            $display("FAIL hold_stable: valid=%0b beat=%h required valid=1 beat=%h", m_valid, got, held);
          end
        end
        if (o_ram_done || prev_hs_last) begin
          checks++;
          if (o_ram_done !== prev_hs_last) begin
            errors++;
            $display("FAIL done_timing: o_ram_done=%0b required=%0b cycle=%0d", o_ram_done, prev_hs_last, cyc);
          end
        end
        if (o_ram_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (m_valid && !prev_vld) vld_rise_cyc = cyc;
        if (m_valid && i_m_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: beat=%h required=none", got);
          end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL beat_data: beat=%h required=%h (data,row,col,lastcol,last)", got, exp);
            end
          end
          beat_cnt++;
          if (m_last_col) lastcol_cnt++;
          if (m_last) begin
            last_cnt++;
            last_hs_cyc = cyc;
          end
          if (m_row == '0 && m_col == '0) first_hs_cyc = cyc;
        end
        prev_stall   = m_valid && !i_m_ready;
        held         = got;
        prev_hs_last = m_valid && i_m_ready && m_last;
        prev_vld     = m_valid;
      end
    end
  end

  task automatic test_reset();
    s_rst = 1'b1; i_ram_empty = 1'b1; i_m_ready = 1'b1;
    repeat (3) @(posedge s_clk);
    #1;
    checks++; if (o_ram_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got=%0d required=0", o_ram_rd_addr); end
    checks++; if (o_ram_done !== 1'b0) begin errors++; $display("FAIL reset_done: got=%0b required=0", o_ram_done); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got=%0b required=0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data: got=%h required=0", m_data); end
    checks++; if (m_row !== '0 || m_col !== '0) begin errors++; $display("FAIL reset_rowcol: got=%0d/%0d required=0/0", m_row, m_col); end
    checks++; if (m_last_col !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got=%0b/%0b required=0/0", m_last_col, m_last); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%0b required=0", o_busy); end
    s_rst = 1'b0;
    repeat (3) @(posedge s_clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got=%0b required=0", o_busy); end
  endtask

  task automatic test_empty_gating_single();
    int busy_seen, vld_seen, addr_moved, done_seen;
    int sb, sd, sl, slc;
    logic [DATA_W-1:0] off;
    busy_seen = 0; vld_seen = 0; addr_moved = 0; done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge s_clk);
      #1;
      if (o_busy) busy_seen++;
      if (m_valid) vld_seen++;
      if (o_ram_rd_addr != '0) addr_moved++;
      if (o_ram_done) done_seen++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL empty_busy: busy cycles=%0d required=0", busy_seen); end
    checks++; if (vld_seen != 0) begin errors++; $display("FAIL empty_valid: valid cycles=%0d required=0", vld_seen); end
    checks++; if (addr_moved + done_seen != 0) begin errors++; $display("FAIL empty_reads: addr moves+dones=%0d required=0", addr_moved + done_seen); end
    off = bank_off(ram_bank);
    push_matrix(off);
    sb = beat_cnt; sd = done_cnt; sl = last_cnt; slc = lastcol_cnt;
    i_ram_empty = 1'b0;
    @(posedge s_clk);
    #1;
    checks++; if (o_busy !== 1'b1 || o_ram_rd_addr !== '0) begin errors++; $display("FAIL start_stream: busy=%0b addr=%0d required busy=1 addr=0", o_busy, o_ram_rd_addr); end
    i_ram_empty = 1'b1;
    @(posedge s_clk);
    #1;
    checks++; if (m_valid !== 1'b0 || o_ram_rd_addr !== 12'd1) begin errors++; $display("FAIL first_latency_early: valid=%0b addr=%0d required valid=0 addr=1", m_valid, o_ram_rd_addr); end
    @(posedge s_clk);
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== off) begin errors++; $display("FAIL first_beat: valid=%0b data=%h required valid=1 data=%h", m_valid, m_data, off); end
    for (int i = 0; i < 3 * NBEATS && done_cnt == sd; i++) @(posedge s_clk);
    checks++; if (done_cnt != sd + 1) begin errors++; $display("FAIL single_done: pulses=%0d required=1", done_cnt - sd); end
    checks++; if (beat_cnt - sb != NBEATS || sb_q.size() != 0) begin errors++; $display("FAIL single_beats: beats=%0d left=%0d required %0d/0", beat_cnt - sb, sb_q.size(), NBEATS); end
    checks++; if (last_hs_cyc - first_hs_cyc != NBEATS - 1) begin errors++; $display("FAIL throughput: span=%0d required=%0d", last_hs_cyc - first_hs_cyc, NBEATS - 1); end
    checks++; if (lastcol_cnt - slc != DIM || last_cnt - sl != 1) begin errors++; $display("FAIL last_flags: last_col=%0d last=%0d required %0d/1", lastcol_cnt - slc, last_cnt - sl, DIM); end
    repeat (4) @(posedge s_clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_after_gap: busy=%0b required=0", o_busy); end
  endtask

  task automatic test_random_ready();
    int sb, sd, sl, slc;
    push_matrix(bank_off(ram_bank));
    sb = beat_cnt; sd = done_cnt; sl = last_cnt; slc = lastcol_cnt;
    rand_ready = 1'b1;
    i_ram_empty = 1'b0;
    for (int i = 0; i < 10 && !o_busy; i++) begin @(posedge s_clk); #1; end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rand_start: busy=%0b required=1", o_busy); end
    i_ram_empty = 1'b1;
    for (int i = 0; i < 8 * NBEATS && done_cnt == sd; i++) @(posedge s_clk);
    rand_ready = 1'b0;
    @(posedge s_clk);
    #2;
    i_m_ready = 1'b1;
    checks++; if (done_cnt != sd + 1) begin errors++; $display("FAIL rand_done: pulses=%0d required=1", done_cnt - sd); end
    checks++; if (beat_cnt - sb != NBEATS || sb_q.size() != 0) begin errors++; $display("FAIL rand_beats: beats=%0d left=%0d required %0d/0", beat_cnt - sb, sb_q.size(), NBEATS); end
    checks++; if (lastcol_cnt - slc != DIM || last_cnt - sl != 1) begin errors++; $display("FAIL rand_last_flags: last_col=%0d last=%0d required %0d/1", lastcol_cnt - slc, last_cnt - sl, DIM); end
    repeat (6) @(posedge s_clk);
  endtask

  task automatic test_back_to_back();
    int sb, sd, d;
    logic b0;
    b0 = ram_bank;
    push_matrix(bank_off(b0));
    push_matrix(bank_off(~b0));
    sb = beat_cnt; sd = done_cnt;
    i_m_ready = 1'b1;
    i_ram_empty = 1'b0;
    for (int i = 0; i < 3 * NBEATS && done_cnt == sd; i++) @(posedge s_clk);
    checks++; if (done_cnt != sd + 1) begin errors++; $display("FAIL b2b_first_done: pulses=%0d required=1", done_cnt - sd); end
    d = done_cyc;
    for (int i = 0; i < 50 && vld_rise_cyc <= d; i++) @(posedge s_clk);
    checks++; if (vld_rise_cyc - d < 5) begin errors++; $display("FAIL b2b_gap: first valid %0d cycles after done, required at least 5", vld_rise_cyc - d); end
    i_ram_empty = 1'b1;
    for (int i = 0; i < 3 * NBEATS && done_cnt == sd + 1; i++) @(posedge s_clk);
    checks++; if (done_cnt != sd + 2) begin errors++; $display("FAIL b2b_second_done: pulses=%0d required=2", done_cnt - sd); end
    checks++; if (beat_cnt - sb != 2 * NBEATS || sb_q.size() != 0) begin errors++; $display("FAIL b2b_beats: beats=%0d left=%0d required %0d/0", beat_cnt - sb, sb_q.size(), 2 * NBEATS); end
    repeat (6) @(posedge s_clk);
  endtask

  task automatic test_mid_reset();
    int sb, sd, rb;
    logic [DATA_W-1:0] off;
    off = bank_off(ram_bank);
    push_matrix(off);
    sb = beat_cnt; sd = done_cnt;
    i_m_ready = 1'b1;
    i_ram_empty = 1'b0;
    for (int i = 0; i < 3000 && beat_cnt - sb < 1000; i++) begin @(posedge s_clk); #1; end
    checks++; if (beat_cnt - sb < 1000) begin errors++; $display("FAIL mid_reach: beats=%0d required>=1000", beat_cnt - sb); end
    s_rst = 1'b1;
    sb_q.delete();
    #1;
    checks++; if (m_valid !== 1'b0 || o_busy !== 1'b0 || o_ram_done !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: valid=%0b busy=%0b done=%0b required 0/0/0", m_valid, o_busy, o_ram_done); end
    checks++; if (o_ram_rd_addr !== '0 || m_data !== '0) begin errors++; $display("FAIL mid_reset_addr_data: addr=%0d data=%h required 0/0", o_ram_rd_addr, m_data); end
    checks++; if (m_row !== '0 || m_col !== '0 || m_last_col !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL mid_reset_tags: row=%0d col=%0d lc=%0b l=%0b required zeros", m_row, m_col, m_last_col, m_last); end
    repeat (3) @(posedge s_clk);
    #1;
    checks++; if (done_cnt != sd) begin errors++; $display("FAIL mid_reset_no_done: pulses=%0d required=0", done_cnt - sd); end
    push_matrix(off);
    rb = beat_cnt;
    s_rst = 1'b0;
    for (int i = 0; i < 10 && !o_busy; i++) begin @(posedge s_clk); #1; end
    i_ram_empty = 1'b1;
    for (int i = 0; i < 3 * NBEATS && done_cnt == sd; i++) @(posedge s_clk);
    checks++; if (done_cnt != sd + 1) begin errors++; $display("FAIL mid_restart_done: pulses=%0d required=1", done_cnt - sd); end
    checks++; if (beat_cnt - rb != NBEATS || sb_q.size() != 0) begin errors++; $display("FAIL mid_restart_beats: beats=%0d left=%0d required %0d/0", beat_cnt - rb, sb_q.size(), NBEATS); end
    repeat (6) @(posedge s_clk);
  endtask

  initial begin
    test_reset();
    test_empty_gating_single();
    test_random_ready();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
